// File: rtl/vga_timing_gen.sv
// vga_timing_gen: SXGA raster timing generator and pixel output stage.
// Two free-running counters give the raster coordinates; visible/frame/line
// flags are decoded straight from them. Colour and both syncs pass through a
// single register stage, so all pins lag the coordinates by the same amount.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 48,
    parameter int   H_SYNC   = 112,
    parameter int   H_BP     = 248,
    parameter int   V_ACTIVE = 1024,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 38,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        CLK_VGA,
    input  logic        RESETN,
    input  logic        CE,
    input  logic [11:0] VGA_RGB_IN,
    output logic [11:0] VGA_horzCoord,
    output logic [11:0] VGA_vertCoord,
    output logic        VGA_ACTIVE,
    output logic        FRAME_START,
    output logic        LINE_END,
    output logic [3:0]  VGA_RED,
    output logic [3:0]  VGA_GREEN,
    output logic [3:0]  VGA_BLUE,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS      = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS      = 12'(V_ACTIVE);
    localparam logic [11:0] HS_FIRST   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    logic        active;
    logic        hs_win;
    logic        vs_win;

    // Decode visible area and sync windows from the current coordinate.
    always_comb begin
        active = (h_q < H_VIS) && (v_q < V_VIS);
        hs_win = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        vs_win = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    end

    // Next raster position: horizontal wraps at line end and carries into vertical.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (CE) begin
            if (h_q == H_LAST) begin
                h_d = 12'd0;
                if (v_q == V_LAST) begin
                    v_d = 12'd0;
                end else begin
                    v_d = v_q + 12'd1;
                end
            end else begin
                h_d = h_q + 12'd1;
            end
        end
    end

    // Next pin values: blank-gated colour and polarity-adjusted syncs, held when CE=0.
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (CE) begin
            rgb_d = active ? VGA_RGB_IN : 12'h000;
            hs_d  = hs_win ? HS_POL : ~HS_POL;
            vs_d  = vs_win ? VS_POL : ~VS_POL;
        end
    end

    // Counter and output-stage registers; reset puts syncs at their inactive level.
    always_ff @(posedge CLK_VGA or negedge RESETN) begin
        if (!RESETN) begin
            h_q   <= 12'd0;
            v_q   <= 12'd0;
            rgb_q <= 12'h000;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign VGA_horzCoord = h_q;
    assign VGA_vertCoord = v_q;
    assign VGA_ACTIVE    = active;
    assign FRAME_START   = (h_q == 12'd0) && (v_q == 12'd0);
    assign LINE_END      = (h_q == H_LAST);
    assign VGA_RED       = rgb_q[11:8];
    assign VGA_GREEN     = rgb_q[7:4];
    assign VGA_BLUE      = rgb_q[3:0];
    assign VGA_HS        = hs_q;
    assign VGA_VS        = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen, using a shrunken raster so whole
// frames fit in a short run: H 16+4+6+6 = 32 clocks, V 8+1+3+2 = 14 lines.
// HS window h=20..25, VS window v=9..11, both active high.
module tb_vga_timing_gen;

    localparam logic [11:0] HT_LAST = 12'd31;
    localparam logic [11:0] VT_LAST = 12'd13;
    localparam logic [11:0] HA      = 12'd16;
    localparam logic [11:0] VA      = 12'd8;
    localparam logic [11:0] HS_LO   = 12'd20;
    localparam logic [11:0] HS_HI   = 12'd25;
    localparam logic [11:0] VS_LO   = 12'd9;
    localparam logic [11:0] VS_HI   = 12'd11;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ce = 1'b0;
    logic [11:0] rgb_in = 12'h000;
    logic [11:0] hc, vc;
    logic        act, fs, le;
    logic [3:0]  red, green, blue;
    logic        hs, vs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        act;
        logic        fs;
        logic        le;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [11:0] mh, mv, mrgb;
    logic        mhs, mvs;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(3), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .CLK_VGA      (clk),
        .RESETN       (rstn),
        .CE           (ce),
        .VGA_RGB_IN   (rgb_in),
        .VGA_horzCoord(hc),
        .VGA_vertCoord(vc),
        .VGA_ACTIVE   (act),
        .FRAME_START  (fs),
        .LINE_END     (le),
        .VGA_RED      (red),
        .VGA_GREEN    (green),
        .VGA_BLUE     (blue),
        .VGA_HS       (hs),
        .VGA_VS       (vs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [11:0] pat(input logic [11:0] h, input logic [11:0] v);
        return {h[3:0], v[3:0], h[3:0] ^ v[3:0] ^ 4'h5};
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.h   = mh;
        e.v   = mv;
        e.act = (mh < HA) && (mv < VA);
        e.fs  = (mh == 12'd0) && (mv == 12'd0);
        e.le  = (mh == HT_LAST);
        e.rgb = mrgb;
        e.hs  = mhs;
        e.vs  = mvs;
        return e;
    endfunction

    task automatic model_reset();
        mh = 12'd0; mv = 12'd0; mrgb = 12'h000; mhs = 1'b0; mvs = 1'b0;
    endtask

    // Drive one cycle's inputs, let the edge happen, then push the expected state.
    task automatic run_cycle(input logic c, input logic [11:0] rgb);
        ce = c;
        rgb_in = rgb;
        @(posedge clk);
        #1;
        if (c) begin
            mrgb = ((mh < HA) && (mv < VA)) ? rgb : 12'h000;
            mhs  = (mh >= HS_LO) && (mh <= HS_HI);
            mvs  = (mv >= VS_LO) && (mv <= VS_HI);
            if (mh == HT_LAST) begin
                mh = 12'd0;
                mv = (mv == VT_LAST) ? 12'd0 : mv + 12'd1;
            end else begin
                mh = mh + 12'd1;
            end
        end
        exp_q.push_back(snapshot());
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_h"},   hc, 12'd0);
        chk({tag, "_v"},   vc, 12'd0);
        chk({tag, "_act"}, {11'd0, act}, 12'd1);
        chk({tag, "_fs"},  {11'd0, fs},  12'd1);
        chk({tag, "_le"},  {11'd0, le},  12'd0);
        chk({tag, "_rgb"}, {red, green, blue}, 12'h000);
        chk({tag, "_hs"},  {11'd0, hs},  12'd0);
        chk({tag, "_vs"},  {11'd0, vs},  12'd0);
    endtask

    // Monitor: on each falling edge compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("h",   hc, e.h);
                chk("v",   vc, e.v);
                chk("act", {11'd0, act}, {11'd0, e.act});
                chk("fs",  {11'd0, fs},  {11'd0, e.fs});
                chk("le",  {11'd0, le},  {11'd0, e.le});
                chk("rgb", {red, green, blue}, e.rgb);
                chk("hs",  {11'd0, hs},  {11'd0, e.hs});
                chk("vs",  {11'd0, vs},  {11'd0, e.vs});
            end
        end
    end

    // Stimulus
    initial begin
        int fs_count;
        int guard;
        model_reset();
        #2;
        chk_reset_state("por");
        @(negedge clk);
        rstn = 1'b1;

        // Two full frames of white input: blanking, sync windows, wrap, frame pulses.
        fs_count = 0;
        for (int i = 0; i < 896; i++) begin
            run_cycle(1'b1, 12'hFFF);
            if (fs) fs_count++;
        end
        chk("fs_pulses_2frames", 12'(fs_count), 12'd2);

        // Coordinate-dependent colour, checks colour/coordinate alignment.
        for (int i = 0; i < 80; i++) run_cycle(1'b1, pat(mh, mv));

        // CE gating: pattern 1,0,0,1 repeated.
        for (int i = 0; i < 40; i++) begin
            run_cycle((i % 4 == 0) || (i % 4 == 3), pat(mh, mv));
        end

        // Advance to h=23, v=10 (inside both sync windows).
        guard = 0;
        while (!(mh == 12'd23 && mv == 12'd10) && guard < 1000) begin
            run_cycle(1'b1, pat(mh, mv));
            guard++;
        end
        chk("reach_sync_point", 12'(guard < 1000), 12'd1);
        @(negedge clk);
        #2;
        chk("pre_rst_hs", {11'd0, hs}, 12'd1);
        chk("pre_rst_vs", {11'd0, vs}, 12'd1);
        chk("pre_rst_h",  hc, 12'd23);
        rstn = 1'b0;
        #1;
        chk_reset_state("async");
        model_reset();
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 40; i++) run_cycle(1'b1, pat(mh, mv));

        @(negedge clk);
        #1;
        chk("queue_drained", 12'(exp_q.size()), 12'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
